// File: rtl/mul_div_iter_if.sv
// Start/finish handshake bundle for the iterative multiply/divide unit.
interface mul_div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] res;
  logic               finish;
  logic               busy;
  logic               div_zero;

  modport master (
    output start, op, a, b,
    input  res, finish, busy, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output res, finish, busy, div_zero
  );
endinterface

// File: rtl/mul_div_iter.sv
// Iterative signed/unsigned multiply (radix-2 shift-add) and divide (restoring) unit.
// Operates on magnitudes and applies two's-complement sign correction in a final FIX cycle.
module mul_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_iter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bz_q, bz_d;
  logic               dz_q, dz_d;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [WIDTH-1:0]   quot, rem_w;

  assign sgn     = bus.op[0];
  assign abs_a   = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b   = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  // Multiply: p holds {partial product high half, remaining multiplier bits}.
  assign sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
  // Divide: p low half shifts dividend bits out and quotient bits in.
  assign shifted = {rem_q[WIDTH-1:0], p_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, m_q};
  assign quot    = p_q[WIDTH-1:0];
  assign rem_w   = rem_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    m_d       = m_q;
    a_raw_d   = a_raw_q;
    p_d       = p_q;
    res_d     = res_q;
    rem_d     = rem_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bz_d      = bz_q;
    dz_d      = dz_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          is_div_d  = bus.op[1];
          a_raw_d   = bus.a;
          bz_d      = (bus.b == '0);
          neg_res_d = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d = sgn & bus.a[WIDTH-1];
          if (bus.op[1]) begin
            m_d = abs_b;
            p_d = {{WIDTH{1'b0}}, abs_a};
          end else begin
            m_d = abs_a;
            p_d = {{WIDTH{1'b0}}, abs_b};
          end
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          if (shifted >= {1'b0, m_q}) begin
            rem_d = diff;
            p_d   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted;
            p_d   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          p_d = {sum, p_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (is_div_q) begin
          if (bz_q) begin
            res_d = {a_raw_q, {WIDTH{1'b1}}};
            dz_d  = 1'b1;
          end else begin
            res_d = {(neg_rem_q ? -rem_w : rem_w), (neg_res_q ? -quot : quot)};
          end
        end else begin
          res_d = neg_res_q ? -p_q : p_q;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      m_q       <= '0;
      a_raw_q   <= '0;
      p_q       <= '0;
      res_q     <= '0;
      rem_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      m_q       <= m_d;
      a_raw_q   <= a_raw_d;
      p_q       <= p_d;
      res_q     <= res_d;
      rem_q     <= rem_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bz_q      <= bz_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.res      = res_q;
  assign bus.finish   = (state_q == StDone);
  assign bus.busy     = (state_q != StIdle);
  assign bus.div_zero = dz_q;
endmodule
